// File: rtl/updown_counter_ctrl_pkg.sv
// updown_counter_ctrl_pkg: command opcodes, FSM states and seek direction helper
package updown_ctrl_pkg;
  typedef enum logic [1:0] {OP_LOAD, OP_UP, OP_DOWN, OP_SEEK} op_e;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STEP, S_SEEK, S_FIN} state_e;
  // Shortest path on a modulo 2^w ring; an exact half-turn goes up.
  function automatic logic seek_dir(input logic [31:0] count, input logic [31:0] target, input int w);
    logic [31:0] diff;
    diff = (target - count) & ((w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1));
    return diff <= (32'd1 << (w - 1));
  endfunction
endpackage

// File: rtl/updown_counter_ctrl_if.sv
// updown_counter_ctrl_if: valid/ready command channel into the counter controller
interface updown_counter_ctrl_if #(parameter int WIDTH = 8) ();
  logic cmd_valid;
  logic cmd_ready;
  logic [1:0] cmd_op;
  logic [WIDTH-1:0] cmd_data;
  modport master(output cmd_valid, cmd_op, cmd_data, input cmd_ready);
  modport slave(input cmd_valid, cmd_op, cmd_data, output cmd_ready);
endinterface

// File: rtl/updown_counter_ctrl.sv
// updown_counter_ctrl: drives updown_counter load/step/seek sequences from commands
// UPDOWN_CTRL_TIMEOUT_EN adds a SEEK watchdog that aborts with err after SEEK_TIMEOUT cycles.
module updown_counter_ctrl
  import updown_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SEEK_TIMEOUT = 512
) (
  input  logic             clk,
  input  logic             rst_n,
  updown_counter_ctrl_if.slave cmd,
  input  logic [WIDTH-1:0] count,
  output logic             en,
  output logic             m,
  output logic             load,
  output logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic             err
);
  state_e r_state, w_next;
  logic [WIDTH-1:0] r_data, r_data_in;
  logic r_m;
  op_e w_op;
  logic w_acc, w_hit, w_to;
  assign w_op = op_e'(cmd.cmd_op);
  assign cmd.cmd_ready = r_state == S_IDLE;
  assign w_acc = cmd.cmd_valid && cmd.cmd_ready;
  assign w_hit = count == r_data;
  assign busy = r_state != S_IDLE;
  assign done = r_state == S_FIN;
  assign data_in = r_data_in;
  assign m = (r_state == S_SEEK) ? seek_dir(32'(count), 32'(r_data), WIDTH) : r_m;
  always_comb begin
    w_next = r_state;
    en = 1'b0;
    load = 1'b0;
    unique case (r_state)
      S_IDLE: if (w_acc) w_next = (w_op == OP_LOAD) ? S_LOAD :
                                  (w_op == OP_SEEK) ? S_SEEK :
                                  (cmd.cmd_data == '0) ? S_FIN : S_STEP;
      S_LOAD: begin
        load = 1'b1;
        w_next = S_FIN;
      end
      S_STEP: begin
        en = 1'b1;
        w_next = (r_data == WIDTH'(1)) ? S_FIN : S_STEP;
      end
      S_SEEK: begin
        en = !w_hit && !w_to;
        w_next = (w_hit || w_to) ? S_FIN : S_SEEK;
      end
      S_FIN: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
  // r_data doubles as remaining step count (STEP) and target (SEEK).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_data <= '0;
      r_data_in <= '0;
      r_m <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_acc) r_data <= cmd.cmd_data;
      else if (r_state == S_STEP) r_data <= r_data - 1'b1;
      if (w_acc && (w_op == OP_UP || w_op == OP_DOWN)) r_m <= w_op == OP_UP;
      if (w_acc && w_op == OP_LOAD) r_data_in <= cmd.cmd_data;
    end
  end
`ifdef UPDOWN_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(SEEK_TIMEOUT + 1);
  logic [TW-1:0] r_tmr;
  logic r_err;
  assign w_to = r_tmr == TW'(SEEK_TIMEOUT - 1);
  assign err = done && r_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmr <= '0;
      r_err <= 1'b0;
    end else begin
      r_tmr <= (r_state == S_SEEK) ? r_tmr + 1'b1 : '0;
      if (w_acc) r_err <= 1'b0;
      else if (r_state == S_SEEK && w_to && !w_hit) r_err <= 1'b1;
    end
  end
`else
  assign w_to = 1'b0;
  assign err = 1'b0;
`endif
endmodule

// File: doc/updown_counter_ctrl.md
Name: updown_counter_ctrl

Overview:
Command-driven controller for the counter side-band interface (en, m, load, data_in), watching the counter's count output. Accepts one command at a time over a valid/ready handshake and issues the load, step or seek sequence on the counter pins. Signals completion with a one-cycle done pulse. Sits beside updown_counter in top; replaces hand-driven stimulus on those pins.

Parameters:
WIDTH, 8, counter/data width
SEEK_TIMEOUT, 512, max SEEK cycles before abort (used only with the optional feature)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller idle; command accepted on cmd_valid && cmd_ready
cmd_op  input  2  00 LOAD, 01 STEP_UP, 10 STEP_DOWN, 11 SEEK
cmd_data  input  WIDTH  load value / step count N / seek target
count  input  WIDTH  counter output
en  output  1  counter enable
m  output  1  counter direction: 1 up, 0 down
load  output  1  counter load strobe
data_in  output  WIDTH  counter load value
busy  output  1  command in progress
done  output  1  one-cycle completion pulse
err  output  1  valid with done; 1 = SEEK timed out

Behaviour:
- Counter contract: load has priority over en; en=1 steps by ±1 modulo 2^WIDTH per clk; the new count is visible the cycle after the en/load cycle.
- Reset (async, rst_n=0): state IDLE; en=0, m=0, load=0, data_in=0, busy=0, done=0, err=0. cmd_ready=1 once rst_n=1.
- cmd_ready = (state==IDLE). Command fields are registered on accept. busy=1 in every state except IDLE.
- States: IDLE, LOAD, STEP, SEEK, FIN.
- IDLE: on accept, go to the state selected by op. STEP_UP and STEP_DOWN go to STEP with m latched (1 or 0) and remaining=N.
- LOAD: exactly one cycle with load=1 and data_in=cmd_data, then FIN. data_in holds its value until the next LOAD.
- STEP: en=1 for exactly N consecutive cycles, then FIN. N=0 goes straight to FIN and en is never asserted.
- SEEK: en and m are combinational from count each cycle.
  - count==target: en=0, go to FIN.
  - Otherwise en=1.
  - Direction: diff=(target-count) mod 2^WIDTH. m=1 if diff<=2^(WIDTH-1), else m=0 (shortest path; a tie goes up).
  - Count ends exactly at target with no overshoot.
- FIN: done=1 for one cycle, then IDLE. en=0 and load=0 in FIN and IDLE.
- Reset mid-command: immediate return to IDLE, command dropped, no done pulse.
- Back-to-back commands: a new accept is possible in the cycle after FIN.

Optional Feature:
Macro UPDOWN_CTRL_TIMEOUT_EN.
- Defined: a SEEK cycle counter increments while in SEEK. When it reaches SEEK_TIMEOUT with count!=target, en drops, the block goes to FIN, and err=1 alongside done. The bench uses this to catch a stuck or miswired counter.
- Undefined: no timer; SEEK waits indefinitely; err is tied to 0.

Decomposition:
- Package updown_ctrl_pkg:
  - op enum (OP_LOAD, OP_UP, OP_DOWN, OP_SEEK)
  - state enum
  - function seek_dir(count, target) returning m
- No sub-module: the FSM plus step/timeout counters fit in one module.

Test Plan:
- LOAD 8'h5A -> load=1 for exactly 1 cycle with data_in=5A; next cycle count=5A; done 1 cycle later; cmd_ready returns to 1.
- count=FD, STEP_UP N=5 -> en=1, m=1 for 5 cycles; count wraps to 02; single done; STEP_DOWN N=0 -> done with no en pulse.
- count=10, SEEK target=0C -> m=0, en=1 for 4 cycles, count stops at 0C. Count=F0, SEEK 10 -> m=1 (wraps through 00), 32 steps, no overshoot.
- Seek tie, count=00, SEEK 80 -> m=1 throughout, 128 steps.
- Async reset asserted mid-STEP (N=20, after 7 steps) -> all outputs 0 immediately, no done; after release cmd_ready=1 and a new LOAD works.
- With UPDOWN_CTRL_TIMEOUT_EN, counter en tied off in the bench, SEEK 33 from 00 -> done with err=1 after 512 SEEK cycles.
